// File: rtl/apb_multi_bridge.sv
// APB requester bridge with one-hot completer decode, wait-state timeout and
// decode-error handling. One transfer is in flight at a time.
// Back-to-back transfers chain from ACCESS straight into SETUP.
module apb_multi_bridge #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 8,
    parameter int NSLAVES   = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic                           transfer,
    input  logic                           READ_WRITE,
    input  logic [ADDRWIDTH:0]             apb_write_paddr,
    input  logic [ADDRWIDTH:0]             apb_read_paddr,
    input  logic [DATAWIDTH-1:0]           apb_write_data,
    output logic [NSLAVES-1:0]             PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDRWIDTH:0]             PADDR,
    output logic [DATAWIDTH-1:0]           PWDATA,
    input  logic [NSLAVES*DATAWIDTH-1:0]   PRDATA,
    input  logic [NSLAVES-1:0]             PREADY,
    input  logic [NSLAVES-1:0]             PSLVERR_in,
    output logic [DATAWIDTH-1:0]           apb_read_data_out,
    output logic                           PSLVERR,
    output logic                           done,
    output logic                           busy
);

    localparam int SELBITS = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int CNTW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNTW-1:0] TO_LAST_C = CNTW'(TO_LAST);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // One-hot completer select for an address; all zero when the index has
    // no completer behind it (decode error).
    function automatic logic [NSLAVES-1:0] decode_sel(input logic [ADDRWIDTH:0] addr);
        logic [SELBITS-1:0] idx;
        logic [NSLAVES-1:0] sel;
        idx = addr[ADDRWIDTH -: SELBITS];
        sel = {NSLAVES{1'b0}};
        for (int i = 0; i < NSLAVES; i++) begin
            if (idx == SELBITS'(i)) begin
                sel[i] = 1'b1;
            end else begin
                sel[i] = 1'b0;
            end
        end
        return sel;
    endfunction

    // Registered state and outputs
    logic [1:0]            state_r;
    logic [ADDRWIDTH:0]    paddr_r;
    logic                  pwrite_r;
    logic [DATAWIDTH-1:0]  pwdata_r;
    logic [NSLAVES-1:0]    psel_r;
    logic                  penable_r;
    logic [DATAWIDTH-1:0]  rdata_r;
    logic                  pslverr_r;
    logic                  done_r;
    logic                  busy_r;
    logic [CNTW-1:0]       cnt_r;

    // Next-state values
    logic [1:0]            nxt_state_s;
    logic [ADDRWIDTH:0]    nxt_paddr_s;
    logic                  nxt_pwrite_s;
    logic [DATAWIDTH-1:0]  nxt_pwdata_s;
    logic [NSLAVES-1:0]    nxt_psel_s;
    logic                  nxt_penable_s;
    logic [DATAWIDTH-1:0]  nxt_rdata_s;
    logic                  nxt_pslverr_s;
    logic                  nxt_done_s;
    logic                  nxt_busy_s;
    logic [CNTW-1:0]       nxt_cnt_s;

    // Completer response for the transfer in flight
    logic [NSLAVES-1:0]    sel_cur_s;
    logic                  dec_err_s;
    logic                  ready_s;
    logic                  slverr_s;
    logic                  timeout_s;
    logic [DATAWIDTH-1:0]  prdata_sel_s;
    logic                  capture_s;
    logic                  complete_s;

    // Select the addressed completer's ready, error and read data
    always_comb begin
        sel_cur_s    = decode_sel(paddr_r);
        dec_err_s    = ~|sel_cur_s;
        ready_s      = |(PREADY & sel_cur_s);
        slverr_s     = |(PSLVERR_in & sel_cur_s);
        timeout_s    = (TIMEOUT > 0) && (cnt_r == TO_LAST_C);
        prdata_sel_s = {DATAWIDTH{1'b0}};
        for (int i = 0; i < NSLAVES; i++) begin
            if (sel_cur_s[i]) begin
                prdata_sel_s = prdata_sel_s | PRDATA[i*DATAWIDTH +: DATAWIDTH];
            end else begin
                prdata_sel_s = prdata_sel_s;
            end
        end
    end

    // Transfer sequencing: IDLE -> SETUP -> ACCESS, completion and capture
    always_comb begin
        nxt_state_s   = state_r;
        nxt_paddr_s   = paddr_r;
        nxt_pwrite_s  = pwrite_r;
        nxt_pwdata_s  = pwdata_r;
        nxt_rdata_s   = rdata_r;
        nxt_pslverr_s = pslverr_r;
        nxt_done_s    = 1'b0;
        nxt_cnt_s     = cnt_r;
        capture_s     = 1'b0;
        complete_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (transfer) begin
                    capture_s   = 1'b1;
                    nxt_state_s = ST_SETUP;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                nxt_state_s = ST_ACCESS;
                nxt_cnt_s   = {CNTW{1'b0}};
            end
            ST_ACCESS: begin
                if (dec_err_s) begin
                    // Nobody answers: finish on the first ACCESS edge
                    complete_s    = 1'b1;
                    nxt_pslverr_s = 1'b1;
                    if (!pwrite_r) begin
                        nxt_rdata_s = {DATAWIDTH{1'b0}};
                    end else begin
                        nxt_rdata_s = rdata_r;
                    end
                end else if (ready_s) begin
                    complete_s    = 1'b1;
                    nxt_pslverr_s = slverr_s;
                    if (!pwrite_r) begin
                        nxt_rdata_s = prdata_sel_s;
                    end else begin
                        nxt_rdata_s = rdata_r;
                    end
                end else if (timeout_s) begin
                    // Completer stalled too long: abandon with an error
                    complete_s    = 1'b1;
                    nxt_pslverr_s = 1'b1;
                    if (!pwrite_r) begin
                        nxt_rdata_s = {DATAWIDTH{1'b0}};
                    end else begin
                        nxt_rdata_s = rdata_r;
                    end
                end else begin
                    nxt_cnt_s = cnt_r + CNTW'(1);
                end

                if (complete_s) begin
                    nxt_done_s = 1'b1;
                    if (transfer) begin
                        capture_s   = 1'b1;
                        nxt_state_s = ST_SETUP;
                    end else begin
                        nxt_state_s = ST_IDLE;
                    end
                end else begin
                    nxt_state_s = ST_ACCESS;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase

        if (capture_s) begin
            nxt_paddr_s  = READ_WRITE ? apb_read_paddr : apb_write_paddr;
            nxt_pwrite_s = ~READ_WRITE;
            if (!READ_WRITE) begin
                nxt_pwdata_s = apb_write_data;
            end else begin
                nxt_pwdata_s = pwdata_r;
            end
        end else begin
            nxt_paddr_s  = nxt_paddr_s;
        end

        if (nxt_state_s != ST_IDLE) begin
            nxt_psel_s = decode_sel(nxt_paddr_s);
        end else begin
            nxt_psel_s = {NSLAVES{1'b0}};
        end
        nxt_penable_s = (nxt_state_s == ST_ACCESS);
        nxt_busy_s    = (nxt_state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            paddr_r   <= {(ADDRWIDTH+1){1'b0}};
            pwrite_r  <= 1'b0;
            pwdata_r  <= {DATAWIDTH{1'b0}};
            psel_r    <= {NSLAVES{1'b0}};
            penable_r <= 1'b0;
            rdata_r   <= {DATAWIDTH{1'b0}};
            pslverr_r <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= {CNTW{1'b0}};
        end else begin
            state_r   <= nxt_state_s;
            paddr_r   <= nxt_paddr_s;
            pwrite_r  <= nxt_pwrite_s;
            pwdata_r  <= nxt_pwdata_s;
            psel_r    <= nxt_psel_s;
            penable_r <= nxt_penable_s;
            rdata_r   <= nxt_rdata_s;
            pslverr_r <= nxt_pslverr_s;
            done_r    <= nxt_done_s;
            busy_r    <= nxt_busy_s;
            cnt_r     <= nxt_cnt_s;
        end
    end

    assign PSEL              = psel_r;
    assign PENABLE           = penable_r;
    assign PWRITE            = pwrite_r;
    assign PADDR             = paddr_r;
    assign PWDATA            = pwdata_r;
    assign apb_read_data_out = rdata_r;
    assign PSLVERR           = pslverr_r;
    assign done              = done_r;
    assign busy              = busy_r;

endmodule

// File: tb/tb_apb_multi_bridge.sv
// Self-checking bench for apb_multi_bridge (3 completers, timeout 4).
// Expectations come from a transaction-level model: access-cycle count,
// error status and read data are derived from the completer's wait count.
module tb_apb_multi_bridge;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic        READ_WRITE;
    logic [8:0]  apb_write_paddr;
    logic [8:0]  apb_read_paddr;
    logic [7:0]  apb_write_data;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [8:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [23:0] PRDATA;
    logic [2:0]  PREADY;
    logic [2:0]  PSLVERR_in;
    logic [7:0]  apb_read_data_out;
    logic        PSLVERR;
    logic        done;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state that persists across transfers
    logic [7:0] exp_rdata;
    logic [7:0] exp_pwdata;
    logic       exp_perr;

    apb_multi_bridge #(
        .DATAWIDTH(8), .ADDRWIDTH(8), .NSLAVES(3), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
        .apb_write_data(apb_write_data), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR_in(PSLVERR_in),
        .apb_read_data_out(apb_read_data_out), .PSLVERR(PSLVERR),
        .done(done), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic scramble_req();
        READ_WRITE      = 1'($urandom);
        apb_write_paddr = 9'($urandom);
        apb_read_paddr  = 9'($urandom);
        apb_write_data  = 8'($urandom);
    endtask

    // One complete transfer started from IDLE; wait_n = cycles PREADY stays low.
    task automatic run_txn(input logic rd, input logic [8:0] addr, input logic [7:0] wd,
                           input int wait_n, input logic err, input logic [7:0] rdv);
        int         idx;
        int         exp_acc;
        int         n_acc;
        logic       dec_err;
        logic       timed_out;
        logic [2:0] exp_sel;

        idx       = int'(addr[8:7]);
        dec_err   = (idx >= 3);
        exp_sel   = dec_err ? 3'b000 : 3'(1 << idx);
        timed_out = !dec_err && (wait_n >= TO);
        exp_acc   = dec_err ? 1 : (timed_out ? TO : wait_n + 1);
        if (!rd) exp_pwdata = wd;

        transfer   = 1'b1;
        READ_WRITE = rd;
        if (rd) begin
            apb_read_paddr  = addr;
            apb_write_paddr = 9'($urandom);
            apb_write_data  = 8'($urandom);
        end else begin
            apb_write_paddr = addr;
            apb_read_paddr  = 9'($urandom);
            apb_write_data  = wd;
        end
        PRDATA     = 24'($urandom);
        PSLVERR_in = 3'($urandom);
        PREADY     = 3'($urandom);
        if (!dec_err) begin
            PRDATA[idx*8 +: 8] = rdv;
            PSLVERR_in[idx]    = err;
            PREADY[idx]        = 1'b0;
        end

        @(negedge PCLK);  // SETUP
        check_eq("setup_psel", PSEL, exp_sel);
        check_eq("setup_penable", PENABLE, 1'b0);
        check_eq("setup_busy", busy, 1'b1);
        check_eq("setup_paddr", PADDR, addr);
        check_eq("setup_pwrite", PWRITE, !rd);
        check_eq("setup_pwdata", PWDATA, exp_pwdata);
        transfer = 1'($urandom);
        scramble_req();

        n_acc = 0;
        for (int g = 0; g < 12; g++) begin
            @(negedge PCLK);
            if (!PENABLE) break;
            n_acc++;
            check_eq("acc_psel", PSEL, exp_sel);
            check_eq("acc_paddr", PADDR, addr);
            check_eq("acc_pwrite", PWRITE, !rd);
            check_eq("acc_pwdata", PWDATA, exp_pwdata);
            check_eq("acc_busy", busy, 1'b1);
            PREADY = 3'($urandom);
            if (!dec_err) PREADY[idx] = (n_acc - 1 >= wait_n);
            transfer = (n_acc >= exp_acc) ? 1'b0 : 1'($urandom);
            scramble_req();
        end

        exp_perr = dec_err | timed_out | err;
        if (rd) exp_rdata = (dec_err || timed_out) ? 8'h00 : rdv;

        check_eq("access_cycles", n_acc, exp_acc);
        check_eq("done_pulse", done, 1'b1);
        check_eq("pslverr", PSLVERR, exp_perr);
        check_eq("rdata", apb_read_data_out, exp_rdata);
        check_eq("idle_psel", PSEL, 3'b000);
        check_eq("idle_busy", busy, 1'b0);
        transfer = 1'b0;
        PREADY   = 3'b000;
        @(negedge PCLK);
        check_eq("done_clear", done, 1'b0);
        check_eq("rdata_hold", apb_read_data_out, exp_rdata);
        check_eq("pslverr_hold", PSLVERR, exp_perr);
    endtask

    initial begin
        PRESET          = 1'b1;
        transfer        = 1'b0;
        READ_WRITE      = 1'b0;
        apb_write_paddr = 9'h000;
        apb_read_paddr  = 9'h000;
        apb_write_data  = 8'h00;
        PRDATA          = 24'h000000;
        PREADY          = 3'b000;
        PSLVERR_in      = 3'b000;
        exp_rdata       = 8'h00;
        exp_pwdata      = 8'h00;
        exp_perr        = 1'b0;

        repeat (3) @(negedge PCLK);
        check_eq("rst_psel", PSEL, 3'b000);
        check_eq("rst_penable", PENABLE, 1'b0);
        check_eq("rst_paddr", PADDR, 9'h000);
        check_eq("rst_pwdata", PWDATA, 8'h00);
        check_eq("rst_rdata", apb_read_data_out, 8'h00);
        check_eq("rst_flags", {PSLVERR, done, busy, PWRITE}, 4'b0000);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Directed cases
        run_txn(1'b0, 9'h085, 8'hA5, 0, 1'b0, 8'h00);    // zero-wait write
        run_txn(1'b1, 9'h100, 8'h00, 2, 1'b0, 8'h3C);    // two waits, read
        run_txn(1'b1, 9'h010, 8'h00, 100, 1'b0, 8'h55);  // timeout
        run_txn(1'b1, 9'h1C0, 8'h00, 0, 1'b0, 8'h77);    // decode error
        run_txn(1'b1, 9'h0A0, 8'h00, TO - 1, 1'b1, 8'h9E); // ready in last allowed cycle
        run_txn(1'b0, 9'h1C4, 8'h5A, 0, 1'b0, 8'h00);    // decode error on write

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 9'($urandom), 8'($urandom),
                    int'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        // Back-to-back zero-wait writes with transfer held high
        transfer        = 1'b1;
        READ_WRITE      = 1'b0;
        apb_write_paddr = 9'h005;
        apb_write_data  = 8'h11;
        PREADY          = 3'b111;
        PSLVERR_in      = 3'b000;
        @(negedge PCLK);
        check_eq("b2b_setup1_psel", PSEL, 3'b001);
        apb_write_paddr = 9'h105;
        apb_write_data  = 8'h22;
        @(negedge PCLK);
        check_eq("b2b_access1", {PSEL, PENABLE}, {3'b001, 1'b1});
        check_eq("b2b_access1_pwdata", PWDATA, 8'h11);
        @(negedge PCLK);
        check_eq("b2b_setup2", {PSEL, PENABLE, done}, {3'b100, 1'b0, 1'b1});
        check_eq("b2b_setup2_addr", PADDR, 9'h105);
        check_eq("b2b_setup2_pwdata", PWDATA, 8'h22);
        transfer = 1'b0;
        @(negedge PCLK);
        check_eq("b2b_access2", {PSEL, PENABLE, done}, {3'b100, 1'b1, 1'b0});
        @(negedge PCLK);
        check_eq("b2b_done2", {PSEL, PENABLE, done, busy}, {3'b000, 1'b0, 1'b1, 1'b0});
        check_eq("b2b_pslverr", PSLVERR, 1'b0);
        exp_pwdata = 8'h22;
        exp_perr   = 1'b0;
        @(negedge PCLK);
        check_eq("b2b_done_clear", done, 1'b0);

        // Reset in the middle of a stalled ACCESS
        run_txn(1'b1, 9'h081, 8'h00, 0, 1'b0, 8'hC3);    // leaves nonzero read data
        transfer       = 1'b1;
        READ_WRITE     = 1'b1;
        apb_read_paddr = 9'h020;
        PREADY         = 3'b000;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        check_eq("rst_mid_in_access", PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check_eq("rst_mid_psel", PSEL, 3'b000);
        check_eq("rst_mid_flags", {PENABLE, busy, done, PSLVERR}, 4'b0000);
        check_eq("rst_mid_rdata", apb_read_data_out, 8'h00);
        check_eq("rst_mid_paddr", PADDR, 9'h000);
        PRESET = 1'b0;
        @(negedge PCLK);
        check_eq("rst_mid_no_done", {done, busy}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_multi_bridge.md
APB_MULTI_BRIDGE -- requirements
Module: apb_multi_bridge

Interface
REQ-001 Parameter: DATAWIDTH, default 8, data bus width.
REQ-002 Parameter: ADDRWIDTH, default 8, address bus is ADDRWIDTH+1 bits, [ADDRWIDTH:0].
REQ-003 Parameter: NSLAVES, default 4, range 1..8, number of APB completers.
REQ-004 Parameter: TIMEOUT, default 15, maximum ACCESS cycles per transfer; 0 disables timeout.
REQ-005 Derived: SELBITS = max(1, clog2(NSLAVES)); slave index = PADDR[ADDRWIDTH -: SELBITS].
REQ-006 Port: PCLK  in  1  single clock; all logic on rising edge.
REQ-007 Port: PRESET  in  1  reset, synchronous, active-high.
REQ-008 Port: transfer  in  1  request a transfer.
REQ-009 Port: READ_WRITE  in  1  1 = read, 0 = write.
REQ-010 Port: apb_write_paddr, apb_read_paddr  in  ADDRWIDTH+1  write / read address.
REQ-011 Port: apb_write_data  in  DATAWIDTH  write data.
REQ-012 Port: PSEL  out  NSLAVES  one-hot completer select.
REQ-013 Port: PENABLE, PWRITE  out  1  APB enable / direction.
REQ-014 Port: PADDR  out  ADDRWIDTH+1; PWDATA  out  DATAWIDTH.
REQ-015 Port: PRDATA  in  NSLAVES*DATAWIDTH  flattened; slave i occupies [i*DATAWIDTH +: DATAWIDTH].
REQ-016 Port: PREADY, PSLVERR_in  in  NSLAVES  per-slave ready / error.
REQ-017 Port: apb_read_data_out  out  DATAWIDTH  registered read result.
REQ-018 Port: PSLVERR  out  1  registered error status of last completed transfer.
REQ-019 Port: done  out  1  one-cycle pulse per completed transfer; busy  out  1  high in SETUP/ACCESS.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-021 In IDLE with transfer=1, the edge SHALL capture PADDR (apb_read_paddr if READ_WRITE=1, else apb_write_paddr), PWRITE=~READ_WRITE, PWDATA=apb_write_data (reads: PWDATA unchanged) and go to SETUP.
REQ-022 In SETUP: PSEL[index]=1 and PENABLE=0; next state ACCESS.
REQ-023 In ACCESS: PSEL held, PENABLE=1; PADDR/PWRITE/PWDATA SHALL stay stable from SETUP until completion.
REQ-024 Completion occurs at the ACCESS edge where PREADY[index]=1: PSLVERR<=PSLVERR_in[index]; on read apb_read_data_out<=PRDATA slice[index]; done=1 in the following cycle.
REQ-025 At completion, transfer=1 SHALL go directly to SETUP with a new capture (no IDLE cycle); transfer=0 SHALL go to IDLE with PSEL=0, PENABLE=0.
REQ-026 transfer and request inputs SHALL be ignored outside IDLE and the completion edge.
REQ-027 Wait counter clears on entering ACCESS, counts ACCESS cycles; if TIMEOUT>0 and PREADY[index]=0 in the TIMEOUT-th ACCESS cycle, the transfer SHALL terminate: PSLVERR<=1, apb_read_data_out<=0 on read, done pulse, next state per REQ-025.
REQ-028 Decode error (index >= NSLAVES): SETUP/ACCESS sequence runs with PSEL all zero; completion SHALL occur at the first ACCESS edge with PSLVERR<=1, read data 0.
REQ-029 apb_read_data_out and PSLVERR SHALL hold until the next completion; writes SHALL not alter apb_read_data_out.
REQ-030 PSEL SHALL never have more than one bit set.

Reset
REQ-031 PRESET=1 at an edge SHALL force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, apb_read_data_out=0, PSLVERR=0, done=0, busy=0, counter=0, regardless of state (including mid-ACCESS).

Verification (DATAWIDTH=8, ADDRWIDTH=8, NSLAVES=3, TIMEOUT=4; index=PADDR[8:7])
REQ-032 Write 0x085, data 0xA5, PREADY[1] high -> SETUP PSEL=3'b010/PENABLE=0, ACCESS PENABLE=1 PWDATA=0xA5, done one cycle, PSLVERR=0.
REQ-033 Read 0x100, PREADY[2] low 2 ACCESS cycles then high, PRDATA slice2=0x3C -> 3 ACCESS cycles, apb_read_data_out=0x3C, PSLVERR=0.
REQ-034 Read 0x010, PREADY[0] stuck low -> exactly 4 ACCESS cycles, then done, PSLVERR=1, apb_read_data_out=0x00.
REQ-035 Read 0x1C0 (index 3) -> PSEL=0 throughout, one ACCESS cycle, PSLVERR=1, data 0x00.
REQ-036 transfer held high, two writes 0x005/0x105 -> ACCESS goes straight to SETUP, PSEL 001 then 100, two done pulses 2 cycles apart (zero-wait).
REQ-037 PRESET=1 during ACCESS with PREADY low -> next cycle PSEL=0, PENABLE=0, busy=0, no done pulse.
